// File: rtl/axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// axi_rd_arbiter
//
// Two-master, one-slave AXI read-channel arbiter. Instruction fetch (M0) and
// data-cache refill (M1) share the on-chip RAM read port. Arbitration is
// round-robin at burst granularity. Only the AR and R channels pass through
// this block.
//
// Ports
//   ACLK, ARESET         clock (rising edge), asynchronous active-high reset
//   Mn_AR*               master n address request (n = 0, 1)
//   Mn_R*                master n read data return
//   S_AR*                address request towards the RAM; S_ARID = granted index
//   S_R*                 read data from the RAM; S_RREADY follows the granted
//                        master's RREADY while a burst is in its data phase
//   GRANT                index of the current or most recently granted master
//   BUSY                 a burst is in its address or data phase
//   ERR                  sticky: a burst's beat count disagreed with ARLEN+1
// ----------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int WIDTH_ID = 2,
    parameter int WIDTH_DA = 32,
    parameter int WIDTH_AD = 32
) (
    input  logic                ACLK,
    input  logic                ARESET,

    input  logic [WIDTH_AD-1:0] M0_ARADDR,
    input  logic [3:0]          M0_ARLEN,
    input  logic                M0_ARVALID,
    output logic                M0_ARREADY,
    output logic [WIDTH_DA-1:0] M0_RDATA,
    output logic                M0_RLAST,
    output logic                M0_RVALID,
    input  logic                M0_RREADY,

    input  logic [WIDTH_AD-1:0] M1_ARADDR,
    input  logic [3:0]          M1_ARLEN,
    input  logic                M1_ARVALID,
    output logic                M1_ARREADY,
    output logic [WIDTH_DA-1:0] M1_RDATA,
    output logic                M1_RLAST,
    output logic                M1_RVALID,
    input  logic                M1_RREADY,

    output logic [WIDTH_ID-1:0] S_ARID,
    output logic [WIDTH_AD-1:0] S_ARADDR,
    output logic [3:0]          S_ARLEN,
    output logic [2:0]          S_ARSIZE,
    output logic [1:0]          S_ARBURST,
    output logic                S_ARVALID,
    input  logic                S_ARREADY,
    input  logic [WIDTH_DA-1:0] S_RDATA,
    input  logic                S_RLAST,
    input  logic                S_RVALID,
    output logic                S_RREADY,

    output logic                GRANT,
    output logic                BUSY,
    output logic                ERR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic                  grant_q;
    logic                  prio_q;
    logic                  s_arvalid_q;
    logic                  err_q;
    logic [WIDTH_AD-1:0]   araddr_q;
    logic [3:0]            arlen_q;
    logic [WIDTH_ID-1:0]   arid_q;
    logic [4:0]            beat_cnt;

    logic                  any_req;
    logic                  pick;
    logic                  r_hs;

    // Read data is a plain copy to both masters; only VALID/LAST are steered.
    assign M0_RDATA  = S_RDATA;
    assign M1_RDATA  = S_RDATA;

    assign S_ARID    = arid_q;
    assign S_ARADDR  = araddr_q;
    assign S_ARLEN   = arlen_q;
    assign S_ARSIZE  = 3'b010;
    assign S_ARBURST = 2'b01;
    assign S_ARVALID = s_arvalid_q;

    assign GRANT     = grant_q;
    assign BUSY      = (state != ST_IDLE);
    assign ERR       = err_q;

    assign any_req   = M0_ARVALID | M1_ARVALID;

    // State register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, request selection and channel steering. The favoured master
    // wins when it requests, otherwise the other requester is taken. ARREADY
    // is held low while reset is asserted so nothing looks accepted then.
    always_comb begin
        state_nxt  = state;
        pick       = 1'b0;
        r_hs       = 1'b0;
        M0_ARREADY = 1'b0;
        M1_ARREADY = 1'b0;
        M0_RVALID  = 1'b0;
        M1_RVALID  = 1'b0;
        M0_RLAST   = 1'b0;
        M1_RLAST   = 1'b0;
        S_RREADY   = 1'b0;

        if (prio_q) begin
            pick = M1_ARVALID;
        end else begin
            pick = ~M0_ARVALID;
        end

        case (state)
            ST_IDLE: begin
                if (any_req && !ARESET) begin
                    state_nxt  = ST_ADDR;
                    M0_ARREADY = ~pick;
                    M1_ARREADY = pick;
                end
            end
            ST_ADDR: begin
                if (S_ARREADY) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                S_RREADY  = grant_q ? M1_RREADY : M0_RREADY;
                M0_RVALID = ~grant_q & S_RVALID;
                M1_RVALID =  grant_q & S_RVALID;
                M0_RLAST  = ~grant_q & S_RLAST;
                M1_RLAST  =  grant_q & S_RLAST;
                r_hs      = S_RVALID & (grant_q ? M1_RREADY : M0_RREADY);
                if (r_hs && S_RLAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture, priority rotation, beat counting and the sticky error.
    // The counter saturates so a runaway slave cannot wrap it back into range.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            grant_q     <= 1'b0;
            prio_q      <= 1'b0;
            s_arvalid_q <= 1'b0;
            err_q       <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arid_q      <= '0;
            beat_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q     <= pick;
                        araddr_q    <= pick ? M1_ARADDR : M0_ARADDR;
                        arlen_q     <= pick ? M1_ARLEN : M0_ARLEN;
                        arid_q      <= {{(WIDTH_ID-1){1'b0}}, pick};
                        s_arvalid_q <= 1'b1;
                        beat_cnt    <= '0;
                    end
                end
                ST_ADDR: begin
                    if (S_ARREADY) begin
                        s_arvalid_q <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (r_hs) begin
                        if (S_RLAST) begin
                            prio_q   <= ~grant_q;
                            beat_cnt <= '0;
                            if (beat_cnt != {1'b0, arlen_q}) begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            if (beat_cnt > {1'b0, arlen_q}) begin
                                err_q <= 1'b1;
                            end
                            if (beat_cnt != 5'd31) begin
                                beat_cnt <= beat_cnt + 5'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_rd_arbiter
//
// Directed bench for axi_rd_arbiter. Inputs change just after the falling
// edge and outputs are sampled 1 ns later, well away from the rising edge.
// The bench plays the part of both masters and of the RAM slave.
// ----------------------------------------------------------------------------
module tb_axi_rd_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;

    logic [31:0] M0_ARADDR, M1_ARADDR;
    logic [3:0]  M0_ARLEN, M1_ARLEN;
    logic        M0_ARVALID, M1_ARVALID;
    logic        M0_ARREADY, M1_ARREADY;
    logic [31:0] M0_RDATA, M1_RDATA;
    logic        M0_RLAST, M1_RLAST;
    logic        M0_RVALID, M1_RVALID;
    logic        M0_RREADY, M1_RREADY;

    logic [1:0]  S_ARID;
    logic [31:0] S_ARADDR;
    logic [3:0]  S_ARLEN;
    logic [2:0]  S_ARSIZE;
    logic [1:0]  S_ARBURST;
    logic        S_ARVALID;
    logic        S_ARREADY;
    logic [31:0] S_RDATA;
    logic        S_RLAST;
    logic        S_RVALID;
    logic        S_RREADY;

    logic        GRANT;
    logic        BUSY;
    logic        ERR;

    int n_cmp  = 0;
    int n_fail = 0;

    axi_rd_arbiter #(.WIDTH_ID(2), .WIDTH_DA(32), .WIDTH_AD(32)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .M0_ARADDR  (M0_ARADDR),
        .M0_ARLEN   (M0_ARLEN),
        .M0_ARVALID (M0_ARVALID),
        .M0_ARREADY (M0_ARREADY),
        .M0_RDATA   (M0_RDATA),
        .M0_RLAST   (M0_RLAST),
        .M0_RVALID  (M0_RVALID),
        .M0_RREADY  (M0_RREADY),
        .M1_ARADDR  (M1_ARADDR),
        .M1_ARLEN   (M1_ARLEN),
        .M1_ARVALID (M1_ARVALID),
        .M1_ARREADY (M1_ARREADY),
        .M1_RDATA   (M1_RDATA),
        .M1_RLAST   (M1_RLAST),
        .M1_RVALID  (M1_RVALID),
        .M1_RREADY  (M1_RREADY),
        .S_ARID     (S_ARID),
        .S_ARADDR   (S_ARADDR),
        .S_ARLEN    (S_ARLEN),
        .S_ARSIZE   (S_ARSIZE),
        .S_ARBURST  (S_ARBURST),
        .S_ARVALID  (S_ARVALID),
        .S_ARREADY  (S_ARREADY),
        .S_RDATA    (S_RDATA),
        .S_RLAST    (S_RLAST),
        .S_RVALID   (S_RVALID),
        .S_RREADY   (S_RREADY),
        .GRANT      (GRANT),
        .BUSY       (BUSY),
        .ERR        (ERR)
    );

    always #5 ACLK = ~ACLK;

    // Hard stop in case the run ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_inputs();
        M0_ARADDR = '0; M0_ARLEN = '0; M0_ARVALID = 1'b0; M0_RREADY = 1'b0;
        M1_ARADDR = '0; M1_ARLEN = '0; M1_ARVALID = 1'b0; M1_RREADY = 1'b0;
        S_ARREADY = 1'b0; S_RDATA = '0; S_RLAST = 1'b0; S_RVALID = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge ACLK);
        ARESET = 1'b1;
        clear_inputs();
        @(negedge ACLK);
        ARESET = 1'b0;
    endtask

    // Slave side of one burst: accept the address, then send nbeats beats with
    // RLAST on beat last_idx (-1 means never). Both masters accept every beat.
    task automatic serve_burst(input int nbeats, input int last_idx, input logic [31:0] base);
        S_ARREADY = 1'b1;
        @(negedge ACLK);
        S_ARREADY = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            S_RVALID  = 1'b1;
            S_RDATA   = base + 32'(i);
            S_RLAST   = (i == last_idx);
            M0_RREADY = 1'b1;
            M1_RREADY = 1'b1;
            @(negedge ACLK);
        end
        S_RVALID  = 1'b0;
        S_RLAST   = 1'b0;
        M0_RREADY = 1'b0;
        M1_RREADY = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge ACLK);
        #1;
        n_cmp++;
        if ({M0_ARREADY, M1_ARREADY, M0_RVALID, M1_RVALID, M0_RLAST, M1_RLAST,
             S_ARVALID, S_RREADY, BUSY, ERR, GRANT} !== 11'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b want %b",
                     {M0_ARREADY, M1_ARREADY, M0_RVALID, M1_RVALID, M0_RLAST, M1_RLAST,
                      S_ARVALID, S_RREADY, BUSY, ERR, GRANT}, 11'b0);
        end
        n_cmp++;
        if ({S_ARID, S_ARLEN, S_ARADDR} !== 38'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_fields: got %h want 0", {S_ARID, S_ARLEN, S_ARADDR});
        end
        n_cmp++;
        if ({S_ARSIZE, S_ARBURST} !== 5'b010_01) begin
            n_fail++;
            $display("[TB] FAIL const_size_burst: got %b want %b", {S_ARSIZE, S_ARBURST}, 5'b010_01);
        end
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        n_cmp++;
        if ({BUSY, S_ARVALID} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL post_reset_idle: got %b want 00", {BUSY, S_ARVALID});
        end
    endtask

    // M0 alone, 4-beat burst at 0x40.
    task automatic test_single_m0();
        @(negedge ACLK);
        M0_ARVALID = 1'b1; M0_ARADDR = 32'h40; M0_ARLEN = 4'd3;
        #1;
        n_cmp++;
        if ({M0_ARREADY, M1_ARREADY, BUSY} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL t1_arready: got %b want 100", {M0_ARREADY, M1_ARREADY, BUSY});
        end
        @(negedge ACLK);
        M0_ARVALID = 1'b0;
        #1;
        n_cmp++;
        if ({S_ARVALID, BUSY, GRANT, S_ARID, S_ARLEN, S_ARADDR} !== {3'b110, 2'd0, 4'd3, 32'h40}) begin
            n_fail++;
            $display("[TB] FAIL t1_addr_phase: got %h want %h",
                     {S_ARVALID, BUSY, GRANT, S_ARID, S_ARLEN, S_ARADDR}, {3'b110, 2'd0, 4'd3, 32'h40});
        end
        S_ARREADY = 1'b1;
        @(negedge ACLK);
        S_ARREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            S_RVALID = 1'b1; S_RDATA = 32'hD000_0000 + 32'(i); S_RLAST = (i == 3);
            M0_RREADY = 1'b1;
            #1;
            n_cmp++;
            if ({M0_RVALID, M0_RLAST, M1_RVALID, M1_RLAST, S_RREADY, S_ARVALID, M0_RDATA} !==
                {1'b1, (i == 3), 4'b0010, 32'hD000_0000 + 32'(i)}) begin
                n_fail++;
                $display("[TB] FAIL t1_beat%0d: got %h want %h", i,
                         {M0_RVALID, M0_RLAST, M1_RVALID, M1_RLAST, S_RREADY, S_ARVALID, M0_RDATA},
                         {1'b1, (i == 3), 4'b0010, 32'hD000_0000 + 32'(i)});
            end
            @(negedge ACLK);
        end
        S_RVALID = 1'b0; S_RLAST = 1'b0; M0_RREADY = 1'b0;
        #1;
        n_cmp++;
        if ({BUSY, ERR} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL t1_done: got %b want 00", {BUSY, ERR});
        end
    endtask

    // Both masters request in the same cycle right after reset.
    task automatic test_simultaneous();
        apply_reset();
        @(negedge ACLK);
        M0_ARVALID = 1'b1; M0_ARADDR = 32'h100; M0_ARLEN = 4'd1;
        M1_ARVALID = 1'b1; M1_ARADDR = 32'h200; M1_ARLEN = 4'd0;
        #1;
        n_cmp++;
        if ({M0_ARREADY, M1_ARREADY} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL t2_first_grant: got %b want 10", {M0_ARREADY, M1_ARREADY});
        end
        @(negedge ACLK);
        M0_ARVALID = 1'b0;
        #1;
        n_cmp++;
        if ({M1_ARREADY, S_ARID, S_ARADDR} !== {1'b0, 2'd0, 32'h100}) begin
            n_fail++;
            $display("[TB] FAIL t2_m0_addr: got %h want %h", {M1_ARREADY, S_ARID, S_ARADDR}, {1'b0, 2'd0, 32'h100});
        end
        serve_burst(2, 1, 32'hD200_0000);
        n_cmp++;
        if ({M0_ARREADY, M1_ARREADY, BUSY} !== 3'b010) begin
            n_fail++;
            $display("[TB] FAIL t2_m1_arready: got %b want 010", {M0_ARREADY, M1_ARREADY, BUSY});
        end
        @(negedge ACLK);
        M1_ARVALID = 1'b0;
        #1;
        n_cmp++;
        if ({M1_ARREADY, GRANT, S_ARID, S_ARADDR} !== {2'b01, 2'd1, 32'h200}) begin
            n_fail++;
            $display("[TB] FAIL t2_m1_addr: got %h want %h", {M1_ARREADY, GRANT, S_ARID, S_ARADDR}, {2'b01, 2'd1, 32'h200});
        end
        serve_burst(1, 0, 32'hD210_0000);
        n_cmp++;
        if ({BUSY, ERR} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL t2_done: got %b want 00", {BUSY, ERR});
        end
    endtask

    // M0 keeps requesting back to back while M1 waits: order M0, M1, M0.
    task automatic test_back_to_back();
        apply_reset();
        @(negedge ACLK);
        M0_ARVALID = 1'b1; M0_ARADDR = 32'hA00; M0_ARLEN = 4'd0;
        M1_ARVALID = 1'b1; M1_ARADDR = 32'hB00; M1_ARLEN = 4'd0;
        #1;
        n_cmp++;
        if ({M0_ARREADY, M1_ARREADY} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL t3_grant1: got %b want 10", {M0_ARREADY, M1_ARREADY});
        end
        @(negedge ACLK);
        M0_ARADDR = 32'hA10;
        #1;
        n_cmp++;
        if ({GRANT, S_ARADDR} !== {1'b0, 32'hA00}) begin
            n_fail++;
            $display("[TB] FAIL t3_burst1: got %h want %h", {GRANT, S_ARADDR}, {1'b0, 32'hA00});
        end
        serve_burst(1, 0, 32'hD300_0000);
        n_cmp++;
        if ({M0_ARREADY, M1_ARREADY} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL t3_grant2: got %b want 01", {M0_ARREADY, M1_ARREADY});
        end
        @(negedge ACLK);
        M1_ARVALID = 1'b0;
        #1;
        n_cmp++;
        if ({GRANT, S_ARADDR} !== {1'b1, 32'hB00}) begin
            n_fail++;
            $display("[TB] FAIL t3_burst2: got %h want %h", {GRANT, S_ARADDR}, {1'b1, 32'hB00});
        end
        serve_burst(1, 0, 32'hD310_0000);
        n_cmp++;
        if ({M0_ARREADY, M1_ARREADY} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL t3_grant3: got %b want 10", {M0_ARREADY, M1_ARREADY});
        end
        @(negedge ACLK);
        M0_ARVALID = 1'b0;
        #1;
        n_cmp++;
        if ({GRANT, S_ARADDR} !== {1'b0, 32'hA10}) begin
            n_fail++;
            $display("[TB] FAIL t3_burst3: got %h want %h", {GRANT, S_ARADDR}, {1'b0, 32'hA10});
        end
        serve_burst(1, 0, 32'hD320_0000);
    endtask

    // Slave stalls S_ARREADY for 5 cycles; M0 requests meanwhile and must wait.
    task automatic test_arready_stall();
        @(negedge ACLK);
        M1_ARVALID = 1'b1; M1_ARADDR = 32'h300; M1_ARLEN = 4'd0;
        #1;
        n_cmp++;
        if (M1_ARREADY !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL t4_arready: got %b want 1", M1_ARREADY);
        end
        @(negedge ACLK);
        M1_ARVALID = 1'b0;
        M0_ARVALID = 1'b1; M0_ARADDR = 32'h310;
        M1_RREADY = 1'b1; M0_RREADY = 1'b1;
        S_RVALID = 1'b1; S_RDATA = 32'hBAD0_0000;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if ({S_ARVALID, BUSY, S_ARADDR} !== {2'b11, 32'h300}) begin
                n_fail++;
                $display("[TB] FAIL t4_hold%0d: got %h want %h", c, {S_ARVALID, BUSY, S_ARADDR}, {2'b11, 32'h300});
            end
            n_cmp++;
            if ({M0_RVALID, M1_RVALID, S_RREADY, M0_ARREADY} !== 4'b0000) begin
                n_fail++;
                $display("[TB] FAIL t4_no_r%0d: got %b want 0000", c, {M0_RVALID, M1_RVALID, S_RREADY, M0_ARREADY});
            end
            @(negedge ACLK);
        end
        S_RVALID = 1'b0;
        M0_ARVALID = 1'b0;
        serve_burst(1, 0, 32'hD400_0000);
        n_cmp++;
        if ({BUSY, ERR} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL t4_done: got %b want 00", {BUSY, ERR});
        end
    endtask

    // M0 drops RREADY for 3 cycles after the first beat; the slave holds the
    // beat until it is accepted.
    task automatic test_rready_backpressure();
        logic [6:0] pat;
        int k;
        pat = 7'b1110001;
        k = 0;
        @(negedge ACLK);
        M0_ARVALID = 1'b1; M0_ARADDR = 32'h500; M0_ARLEN = 4'd3;
        @(negedge ACLK);
        M0_ARVALID = 1'b0;
        S_ARREADY = 1'b1;
        @(negedge ACLK);
        S_ARREADY = 1'b0;
        for (int c = 0; c < 7; c++) begin
            S_RVALID = 1'b1; S_RDATA = 32'hD500_0000 + 32'(k); S_RLAST = (k == 3);
            M0_RREADY = pat[c];
            #1;
            n_cmp++;
            if (S_RREADY !== pat[c]) begin
                n_fail++;
                $display("[TB] FAIL t5_srready%0d: got %b want %b", c, S_RREADY, pat[c]);
            end
            n_cmp++;
            if ({M0_RVALID, M0_RLAST, M0_RDATA} !== {1'b1, (k == 3), 32'hD500_0000 + 32'(k)}) begin
                n_fail++;
                $display("[TB] FAIL t5_beat%0d: got %h want %h", c, {M0_RVALID, M0_RLAST, M0_RDATA},
                         {1'b1, (k == 3), 32'hD500_0000 + 32'(k)});
            end
            if (pat[c]) k++;
            @(negedge ACLK);
        end
        S_RVALID = 1'b0; S_RLAST = 1'b0; M0_RREADY = 1'b0;
        #1;
        n_cmp++;
        if ({BUSY, ERR} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL t5_done: got %b want 00", {BUSY, ERR});
        end
    endtask

    // Early RLAST, sticky ERR, overrun without RLAST, reset mid-burst.
    task automatic test_err_and_reset();
        @(negedge ACLK);
        M1_ARVALID = 1'b1; M1_ARADDR = 32'h600; M1_ARLEN = 4'd3;
        @(negedge ACLK);
        M1_ARVALID = 1'b0;
        serve_burst(3, 2, 32'hD600_0000);
        n_cmp++;
        if ({BUSY, ERR} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL t6_early_rlast: got %b want 01", {BUSY, ERR});
        end
        @(negedge ACLK);
        M0_ARVALID = 1'b1; M0_ARADDR = 32'h610; M0_ARLEN = 4'd0;
        @(negedge ACLK);
        M0_ARVALID = 1'b0;
        serve_burst(1, 0, 32'hD610_0000);
        n_cmp++;
        if ({BUSY, ERR} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL t6_sticky: got %b want 01", {BUSY, ERR});
        end
        apply_reset();
        #1;
        n_cmp++;
        if (ERR !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL t6_err_cleared: got %b want 0", ERR);
        end
        @(negedge ACLK);
        M1_ARVALID = 1'b1; M1_ARADDR = 32'h700; M1_ARLEN = 4'd0;
        @(negedge ACLK);
        M1_ARVALID = 1'b0;
        serve_burst(2, -1, 32'hD700_0000);
        n_cmp++;
        if ({BUSY, ERR, GRANT} !== 3'b111) begin
            n_fail++;
            $display("[TB] FAIL t6_overrun: got %b want 111", {BUSY, ERR, GRANT});
        end
        S_RVALID = 1'b1; S_RLAST = 1'b1; M1_RREADY = 1'b1; M1_ARVALID = 1'b1;
        ARESET = 1'b1;
        #1;
        n_cmp++;
        if ({M0_ARREADY, M1_ARREADY, M0_RVALID, M1_RVALID, M0_RLAST, M1_RLAST,
             S_ARVALID, S_RREADY, BUSY, ERR, GRANT} !== 11'b0) begin
            n_fail++;
            $display("[TB] FAIL t6_midreset_ctrl: got %b want %b",
                     {M0_ARREADY, M1_ARREADY, M0_RVALID, M1_RVALID, M0_RLAST, M1_RLAST,
                      S_ARVALID, S_RREADY, BUSY, ERR, GRANT}, 11'b0);
        end
        n_cmp++;
        if ({S_ARID, S_ARLEN, S_ARADDR} !== 38'b0) begin
            n_fail++;
            $display("[TB] FAIL t6_midreset_fields: got %h want 0", {S_ARID, S_ARLEN, S_ARADDR});
        end
        @(negedge ACLK);
        clear_inputs();
        ARESET = 1'b0;
    endtask

    initial begin
        clear_inputs();
        ARESET = 1'b1;
        $display("[TB] starting axi_rd_arbiter bench");
        test_reset();
        test_single_m0();
        test_simultaneous();
        test_back_to_back();
        test_arready_stall();
        test_rready_backpressure();
        test_err_and_reset();
        repeat (2) @(negedge ACLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
